// File: rtl/float_quadratic_roots_pkg.sv
// float_quadratic_roots shared types, FP64 constants and helpers
// Optional double-root shortcut macro: FLOAT_ROOTS_DOUBLE_ROOT_EN
package float_quadratic_roots_pkg;

  localparam int FLEN = 64;

  localparam logic [FLEN-1:0] FP_TWO  = 64'h4000_0000_0000_0000;
  localparam logic [FLEN-1:0] FP_ZERO = 64'h0000_0000_0000_0000;
  localparam logic [FLEN-1:0] EXP_MSK = 64'h7FF0_0000_0000_0000;

  typedef enum logic [2:0] {
    IDLE,
    SQRT,
    SUMS,
    DIV,
    DONE
  } state_e;

  typedef enum logic [2:0] {
    OP_ADD,
    OP_SUB,
    OP_MUL,
    OP_DIV,
    OP_SQRT
  } fp_op_e;

  function automatic logic is_nan_or_inf(
    input logic [FLEN-1:0] x
  );
    return (x & EXP_MSK) == EXP_MSK;
  endfunction

  function automatic logic is_zero(
    input logic [FLEN-1:0] x
  );
    return (x << 1) == '0;
  endfunction

endpackage

// File: rtl/float_quadratic_roots_fp_pair_join.sv
// Issues a paired up_valid pulse and joins both sub-unit completions
// A skipped lane is pre-marked done and never pulsed
module fp_pair_join
  import float_quadratic_roots_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            en,
  input  logic            skip_0,
  input  logic            skip_1,
  input  logic            dv_0,
  input  logic            dv_1,
  input  logic [FLEN-1:0] val_0,
  input  logic [FLEN-1:0] val_1,
  input  logic            fault_0,
  input  logic            fault_1,
  output logic            up_0,
  output logic            up_1,
  output logic [FLEN-1:0] res_0,
  output logic [FLEN-1:0] res_1,
  output logic            err,
  output logic            both_done
);

  logic done_0;
  logic done_1;
  logic hit_0;
  logic hit_1;

  assign hit_0     = en & dv_0 & ~done_0;
  assign hit_1     = en & dv_1 & ~done_1;
  assign both_done = done_0 & done_1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      up_0   <= 1'b0;
      up_1   <= 1'b0;
      done_0 <= 1'b0;
      done_1 <= 1'b0;
      res_0  <= '0;
      res_1  <= '0;
      err    <= 1'b0;
    end else begin
      up_0 <= start & ~skip_0;
      up_1 <= start & ~skip_1;
      if (start) begin
        done_0 <= skip_0;
        done_1 <= skip_1;
        err    <= 1'b0;
      end else begin
        if (hit_0) begin
          done_0 <= 1'b1;
          res_0  <= val_0;
        end
        if (hit_1) begin
          done_1 <= 1'b1;
          res_1  <= val_1;
        end
        err <= err | (hit_0 & fault_0) | (hit_1 & fault_1);
      end
    end
  end

endmodule

// File: rtl/float_quadratic_roots_fp_unit.sv
// Variable-latency FP64 operator: up_valid/down_valid/error handshake
// Latency is 1..4 cycles, set by the two low exponent bits of x
module fp_unit
  import float_quadratic_roots_pkg::*;
#(
  parameter fp_op_e OP = OP_ADD
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            up_valid,
  input  logic [FLEN-1:0] x,
  input  logic [FLEN-1:0] y,
  output logic            down_valid,
  output logic [FLEN-1:0] res,
  output logic            error
);

  logic            busy;
  logic [2:0]      cnt;
  logic [FLEN-1:0] val;

  function automatic logic [FLEN-1:0] eval(
    input logic [FLEN-1:0] p,
    input logic [FLEN-1:0] q
  );
    real rp;
    real rq;
    real rr;
    rp = $bitstoreal(p);
    rq = $bitstoreal(q);
    case (OP)
      OP_ADD:  rr = rp + rq;
      OP_SUB:  rr = rp - rq;
      OP_MUL:  rr = rp * rq;
      OP_DIV:  rr = rp / rq;
      default: rr = $sqrt(rp);
    endcase
    return $realtobits(rr);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy       <= 1'b0;
      cnt        <= '0;
      val        <= '0;
      down_valid <= 1'b0;
      res        <= '0;
      error      <= 1'b0;
    end else begin
      down_valid <= 1'b0;
      if (up_valid && !busy) begin
        busy <= 1'b1;
        cnt  <= {1'b0, x[53:52]} + 3'd1;
        val  <= eval(x, y);
      end else if (busy) begin
        cnt <= cnt - 3'd1;
        if (cnt == 3'd1) begin
          busy       <= 1'b0;
          down_valid <= 1'b1;
          res        <= val;
          error      <= is_nan_or_inf(val);
        end
      end
    end
  end

endmodule

// File: rtl/float_quadratic_roots.sv
// Real roots (-b +/- sqrt d) / 2a sequenced over FP64 sub-units
// Macro FLOAT_ROOTS_DOUBLE_ROOT_EN: d == 0 runs one divide for both roots
module float_quadratic_roots
  import float_quadratic_roots_pkg::*;
#(
  parameter int WDOG_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            arg_vld,
  input  logic [FLEN-1:0] a,
  input  logic [FLEN-1:0] b,
  input  logic [FLEN-1:0] d,
  input  logic            d_negative,
  input  logic            d_err,
  output logic            res_vld,
  output logic [FLEN-1:0] root_0,
  output logic [FLEN-1:0] root_1,
  output logic            no_real,
  output logic            err,
  output logic            busy
);

  localparam int WW = $clog2(WDOG_CYCLES + 1);

  state_e state;
  state_e state_nxt;

  logic [FLEN-1:0] a_r;
  logic [FLEN-1:0] b_r;
  logic [FLEN-1:0] d_r;
  logic            cls_err;
  logic            cls_cplx;
  logic            dbl;
  logic            abort;
  logic            err_acc;
  logic [WW-1:0]   wdog;

  logic            bad_in;
  logic            dbl_in;
  logic            waiting;
  logic            timeout;
  logic            stage_done;
  logic            stage_err;
  logic            start_sq;
  logic            start_sum;
  logic            start_div;
  logic [FLEN-1:0] neg_b;
  logic [FLEN-1:0] n0_op;

  logic [FLEN-1:0] o_r0;
  logic [FLEN-1:0] o_r1;
  logic            o_err;
  logic            o_nr;

  // lanes: 0 sqrt, 1 mult, 2 add, 3 sub, 4 div0, 5 div1
  logic [5:0]            up;
  logic [5:0]            dv;
  logic [5:0]            flt;
  logic [5:0][FLEN-1:0]  val;
  logic [5:0][FLEN-1:0]  jr;
  logic [2:0]            jerr;
  logic [2:0]            jdone;

  assign bad_in = d_err | is_nan_or_inf(a) | is_nan_or_inf(b)
                | is_zero(a);

`ifdef FLOAT_ROOTS_DOUBLE_ROOT_EN
  assign dbl_in = is_zero(d) & ~d_negative;
`else
  assign dbl_in = 1'b0;
`endif

  assign neg_b   = {~b_r[FLEN-1], b_r[FLEN-2:0]};
  assign n0_op   = dbl ? neg_b : jr[2];
  assign busy    = state != IDLE;
  assign waiting = state inside {SQRT, SUMS, DIV};
  assign timeout = waiting && (wdog == WW'(WDOG_CYCLES));

  assign start_sq  = state == IDLE && state_nxt == SQRT;
  assign start_sum = state == SQRT && state_nxt == SUMS;
  assign start_div = state != DIV && state_nxt == DIV;

  always_comb begin
    stage_done = 1'b0;
    stage_err  = 1'b0;
    unique case (1'b1)
      state == SQRT: begin
        stage_done = jdone[0];
        stage_err  = jerr[0];
      end
      state == SUMS: begin
        stage_done = jdone[1];
        stage_err  = jerr[1];
      end
      state == DIV: begin
        stage_done = jdone[2];
        stage_err  = jerr[2];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (arg_vld)
          state_nxt = (bad_in || d_negative) ? DONE : SQRT;
      SQRT:
        if (jdone[0])     state_nxt = dbl ? DIV : SUMS;
        else if (timeout) state_nxt = DONE;
      SUMS:
        if (jdone[1] || timeout) state_nxt = jdone[1] ? DIV : DONE;
      DIV:
        if (jdone[2] || timeout) state_nxt = DONE;
      DONE:
        state_nxt = IDLE;
      default:
        state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_r0  = FP_ZERO;
    o_r1  = FP_ZERO;
    o_err = 1'b0;
    o_nr  = 1'b0;
    if (cls_err || abort) begin
      o_err = 1'b1;
    end else if (cls_cplx) begin
      o_nr = 1'b1;
    end else begin
      o_r0  = jr[4];
      o_r1  = dbl ? jr[4] : jr[5];
      o_err = err_acc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_r      <= '0;
      b_r      <= '0;
      d_r      <= '0;
      cls_err  <= 1'b0;
      cls_cplx <= 1'b0;
      dbl      <= 1'b0;
      abort    <= 1'b0;
      err_acc  <= 1'b0;
      wdog     <= '0;
    end else begin
      if (state_nxt != state) wdog <= '0;
      else if (waiting)       wdog <= wdog + WW'(1);
      if (state == IDLE && arg_vld) begin
        a_r      <= a;
        b_r      <= b;
        d_r      <= d;
        cls_err  <= bad_in;
        cls_cplx <= d_negative & ~bad_in;
        dbl      <= dbl_in;
        abort    <= 1'b0;
        err_acc  <= 1'b0;
      end else begin
        abort   <= abort | (timeout & ~stage_done);
        err_acc <= err_acc | (stage_done & stage_err);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_vld <= 1'b0;
      root_0  <= '0;
      root_1  <= '0;
      no_real <= 1'b0;
      err     <= 1'b0;
    end else begin
      res_vld <= state == DONE;
      if (state == DONE) begin
        root_0  <= o_r0;
        root_1  <= o_r1;
        no_real <= o_nr;
        err     <= o_err;
      end
    end
  end

  fp_unit #(.OP(OP_SQRT)) u_f_sqrt (
    .clk(clk), .rst(rst), .up_valid(up[0]),
    .x(d_r), .y(FP_ZERO),
    .down_valid(dv[0]), .res(val[0]), .error(flt[0])
  );

  fp_unit #(.OP(OP_MUL)) u_f_mult (
    .clk(clk), .rst(rst), .up_valid(up[1]),
    .x(a_r), .y(FP_TWO),
    .down_valid(dv[1]), .res(val[1]), .error(flt[1])
  );

  fp_unit #(.OP(OP_ADD)) u_f_add (
    .clk(clk), .rst(rst), .up_valid(up[2]),
    .x(neg_b), .y(jr[0]),
    .down_valid(dv[2]), .res(val[2]), .error(flt[2])
  );

  fp_unit #(.OP(OP_SUB)) u_f_sub (
    .clk(clk), .rst(rst), .up_valid(up[3]),
    .x(neg_b), .y(jr[0]),
    .down_valid(dv[3]), .res(val[3]), .error(flt[3])
  );

  fp_unit #(.OP(OP_DIV)) u_f_div0 (
    .clk(clk), .rst(rst), .up_valid(up[4]),
    .x(n0_op), .y(jr[1]),
    .down_valid(dv[4]), .res(val[4]), .error(flt[4])
  );

  fp_unit #(.OP(OP_DIV)) u_f_div1 (
    .clk(clk), .rst(rst), .up_valid(up[5]),
    .x(jr[3]), .y(jr[1]),
    .down_valid(dv[5]), .res(val[5]), .error(flt[5])
  );

  fp_pair_join u_join_sq (
    .clk(clk), .rst(rst), .start(start_sq), .en(state == SQRT),
    .skip_0(dbl_in), .skip_1(1'b0),
    .dv_0(dv[0]), .dv_1(dv[1]), .val_0(val[0]), .val_1(val[1]),
    .fault_0(flt[0]), .fault_1(flt[1]),
    .up_0(up[0]), .up_1(up[1]), .res_0(jr[0]), .res_1(jr[1]),
    .err(jerr[0]), .both_done(jdone[0])
  );

  fp_pair_join u_join_sum (
    .clk(clk), .rst(rst), .start(start_sum), .en(state == SUMS),
    .skip_0(1'b0), .skip_1(1'b0),
    .dv_0(dv[2]), .dv_1(dv[3]), .val_0(val[2]), .val_1(val[3]),
    .fault_0(flt[2]), .fault_1(flt[3]),
    .up_0(up[2]), .up_1(up[3]), .res_0(jr[2]), .res_1(jr[3]),
    .err(jerr[1]), .both_done(jdone[1])
  );

  fp_pair_join u_join_div (
    .clk(clk), .rst(rst), .start(start_div), .en(state == DIV),
    .skip_0(1'b0), .skip_1(dbl),
    .dv_0(dv[4]), .dv_1(dv[5]), .val_0(val[4]), .val_1(val[5]),
    .fault_0(flt[4]), .fault_1(flt[5]),
    .up_0(up[4]), .up_1(up[5]), .res_0(jr[4]), .res_1(jr[5]),
    .err(jerr[2]), .both_done(jdone[2])
  );

endmodule

// File: tb/tb_float_quadratic_roots.sv
// Bench for float_quadratic_roots: directed steps, result scoreboard
// Builds with or without FLOAT_ROOTS_DOUBLE_ROOT_EN
module tb_float_quadratic_roots;
  import float_quadratic_roots_pkg::*;

  typedef struct packed {
    logic [63:0] r0;
    logic [63:0] r1;
    logic        e;
    logic        nr;
  } exp_t;

  localparam logic [63:0] ONE   = 64'h3FF0_0000_0000_0000;
  localparam logic [63:0] TWO   = 64'h4000_0000_0000_0000;
  localparam logic [63:0] FOUR  = 64'h4010_0000_0000_0000;
  localparam logic [63:0] M1    = 64'hBFF0_0000_0000_0000;
  localparam logic [63:0] M3    = 64'hC008_0000_0000_0000;
  localparam logic [63:0] M4    = 64'hC010_0000_0000_0000;
  localparam logic [63:0] M10   = 64'hC024_0000_0000_0000;
  localparam logic [63:0] F36   = 64'h4042_0000_0000_0000;
  localparam logic [63:0] PINF  = 64'h7FF0_0000_0000_0000;
  localparam logic [63:0] NINF  = 64'hFFF0_0000_0000_0000;
  localparam logic [63:0] Z     = 64'h0000_0000_0000_0000;
  localparam logic [63:0] NZ    = 64'h8000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        arg_vld = 1'b0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic [63:0] d = '0;
  logic        d_negative = 1'b0;
  logic        d_err = 1'b0;
  logic        res_vld;
  logic [63:0] root_0;
  logic [63:0] root_1;
  logic        no_real;
  logic        err;
  logic        busy;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_res = 0;
  int   cyc = 0;
  int   res_cyc = 0;
  int   acc_cyc = 0;
  int   lat_d0;
  int   lat_d1;
  logic prev_vld = 1'b0;

  float_quadratic_roots dut (
    .clk(clk), .rst(rst), .arg_vld(arg_vld),
    .a(a), .b(b), .d(d),
    .d_negative(d_negative), .d_err(d_err),
    .res_vld(res_vld), .root_0(root_0), .root_1(root_1),
    .no_real(no_real), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] want);
    n_chk++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s got %h want %h", tag, got, want);
    end
  endtask

  function automatic exp_t mk(input logic [63:0] r0, input logic [63:0] r1,
                              input logic e, input logic nr);
    exp_t x;
    x.r0 = r0;
    x.r1 = r1;
    x.e  = e;
    x.nr = nr;
    return x;
  endfunction

  always @(negedge clk) begin
    if (rst && res_vld) begin
      n_res++;
      res_cyc = cyc;
      check("res_vld_width", prev_vld, 1'b0);
      check("sb_nonempty", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("root_0", root_0, mon_e.r0);
        check("root_1", root_1, mon_e.r1);
        check("err", err, mon_e.e);
        check("no_real", no_real, mon_e.nr);
      end
    end
    prev_vld = res_vld;
  end

  task automatic send(input logic [63:0] ta, input logic [63:0] tb_,
                      input logic [63:0] td, input logic tn,
                      input logic te, input exp_t ex);
    int k;
    k = 0;
    while (busy && k < 1000) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("idle_before_send", busy, 1'b0);
    a = ta;
    b = tb_;
    d = td;
    d_negative = tn;
    d_err = te;
    arg_vld = 1'b1;
    sb.push_back(ex);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    arg_vld = 1'b0;
  endtask

  task automatic wait_res(input int target);
    int k;
    k = 0;
    while (n_res < target && k < 2000) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("res_timeout", n_res >= target, 1'b1);
  endtask

  initial begin
    int k;
    repeat (3) @(negedge clk);
    check("rst_res_vld", res_vld, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_no_real", no_real, 1'b0);
    check("rst_root_0", root_0, Z);
    check("rst_root_1", root_1, Z);
    rst = 1'b1;
    @(negedge clk);

    send(ONE, M3, ONE, 1'b0, 1'b0, mk(TWO, ONE, 1'b0, 1'b0));
    wait_res(1);
    lat_d1 = res_cyc - acc_cyc;

    send(ONE, TWO, Z, 1'b0, 1'b0, mk(M1, M1, 1'b0, 1'b0));
    wait_res(2);
    lat_d0 = res_cyc - acc_cyc;
`ifdef FLOAT_ROOTS_DOUBLE_ROOT_EN
    check("dbl_root_faster", lat_d0 < lat_d1, 1'b1);
`else
    check("full_path_latency", lat_d0 >= 12, 1'b1);
`endif

    send(ONE, Z, M4, 1'b1, 1'b0, mk(Z, Z, 1'b0, 1'b1));
    check("cplx_busy_n1", busy, 1'b1);
    check("cplx_vld_n1", res_vld, 1'b0);
    @(posedge clk);
    #1;
    check("cplx_busy_n2", busy, 1'b0);
    check("cplx_vld_n2", res_vld, 1'b1);
    wait_res(3);

    send(Z, ONE, ONE, 1'b0, 1'b0, mk(Z, Z, 1'b1, 1'b0));
    wait_res(4);
    send(ONE, PINF, ONE, 1'b0, 1'b0, mk(Z, Z, 1'b1, 1'b0));
    wait_res(5);
    send(ONE, ONE, ONE, 1'b0, 1'b1, mk(Z, Z, 1'b1, 1'b0));
    wait_res(6);
    send(NZ, ONE, ONE, 1'b0, 1'b0, mk(Z, Z, 1'b1, 1'b0));
    wait_res(7);

    send(ONE, Z, PINF, 1'b0, 1'b0, mk(PINF, NINF, 1'b1, 1'b0));
    wait_res(8);

    send(M1, Z, FOUR, 1'b0, 1'b0, mk(M1, ONE, 1'b0, 1'b0));
    @(negedge clk);
    a = Z;
    arg_vld = 1'b1;
    @(negedge clk);
    arg_vld = 1'b0;
    wait_res(9);
    repeat (20) @(negedge clk);
    #1;
    check("no_extra_res", n_res, 9);
    check("sb_drained", sb.size(), 0);

    send(TWO, M10, F36, 1'b0, 1'b0, mk(FOUR, ONE, 1'b0, 1'b0));
    k = 0;
    while (dut.state != DIV && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("reach_div", dut.state == DIV, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_root_0", root_0, Z);
    check("mid_rst_root_1", root_1, Z);
    check("mid_rst_err", err, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send(TWO, M10, F36, 1'b0, 1'b0, mk(FOUR, ONE, 1'b0, 1'b0));
    wait_res(10);
    check("post_rst_count", n_res, 10);

    a = ONE;
    b = M3;
    d = ONE;
    d_negative = 1'b0;
    d_err = 1'b0;
    repeat (3) sb.push_back(mk(TWO, ONE, 1'b0, 1'b0));
    arg_vld = 1'b1;
    k = 0;
    while (n_res < 13 && k < 2000) begin
      @(negedge clk);
      #1;
      k++;
    end
    arg_vld = 1'b0;
    check("held_res_count", n_res, 13);
    repeat (40) @(negedge clk);
    #1;
    check("held_no_extra", n_res, 13);
    check("held_sb_drained", sb.size(), 0);
    check("held_idle", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
